poly_angle_sort: RTL

- Parametrised angular sorter for the convex-polygon coverage flow. Replaces the fixed six-point vertex sorter.
- Takes NUM_PTS points. Point 0 is the pivot. The block orders the remaining points clockwise around the pivot.
- Method: odd-even transposition network on pivot-relative vectors, one phase per cycle. Start/busy/done handshake.
- Sits between the point loader and the area/inside-test stage.

---
 rtl/poly_angle_sort_if.sv | 22 ++
 rtl/poly_angle_sort.sv | 104 ++++++++++
 2 files changed

// File: rtl/poly_angle_sort_if.sv
// poly_angle_sort_if: start/busy/done handshake and packed point buses for poly_angle_sort.
//   start   - request a sort (master -> slave)
//   ccw     - counterclockwise order select, present only with SORT_DIR_SEL_EN
//   pts_in  - NUM_PTS packed {x,y} points, point 0 is the pivot
//   busy    - sorter is in LOAD, PHASE or DONE
//   done    - one-cycle pulse, pts_out valid from this cycle
//   pts_out - sorted points, same packing as pts_in
interface poly_angle_sort_if #(parameter int NUM_PTS = 6, parameter int COORD_W = 10);
   logic start;
   logic busy;
   logic done;
   logic [NUM_PTS*2*COORD_W-1:0] pts_in;
   logic [NUM_PTS*2*COORD_W-1:0] pts_out;
`ifdef SORT_DIR_SEL_EN
   logic ccw;
   modport master(output start, ccw, pts_in, input busy, done, pts_out);
   modport slave(input start, ccw, pts_in, output busy, done, pts_out);
`else
   modport master(output start, pts_in, input busy, done, pts_out);
   modport slave(input start, pts_in, output busy, done, pts_out);
`endif
endinterface

// File: rtl/poly_angle_sort.sv
// poly_angle_sort: clockwise angular sort of NUM_PTS-1 points around pivot point 0.
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - poly_angle_sort_if slave: start, pts_in, busy, done, pts_out (+ ccw)
// Optional macro SORT_DIR_SEL_EN adds bus.ccw, latched with start, selecting counterclockwise order.
// Sorting is an odd-even transposition network over pivot-relative vectors, one phase per cycle.
module poly_angle_sort #(
   parameter int NUM_PTS = 6,
   parameter int COORD_W = 10
) (
   input logic clk,
   input logic reset,
   poly_angle_sort_if.slave bus
);
   localparam int K = NUM_PTS - 1;
   localparam int PW = 2 * COORD_W;
   localparam int VW = COORD_W + 1;
   localparam int XW = 2 * COORD_W + 3;
   localparam int CW = $clog2(K);
   typedef enum logic [1:0] {IDLE, LOAD, PHASE, DONE} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] cnt;
   logic [NUM_PTS*PW-1:0] pts_q;
   logic signed [VW-1:0] vx [K];
   logic signed [VW-1:0] vy [K];
   logic signed [VW-1:0] nx [K];
   logic signed [VW-1:0] ny [K];
   logic signed [XW-1:0] cr [K-1];
   logic [K-2:0] sw;
   logic last;
`ifdef SORT_DIR_SEL_EN
   logic ccw_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) ccw_q <= 1'b0;
      else if (state == IDLE && bus.start) ccw_q <= bus.ccw;
`else
   logic ccw_q;
   assign ccw_q = 1'b0;
`endif
   assign last = cnt == CW'(K - 1);
   assign bus.busy = state != IDLE;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state == IDLE  ? (bus.start ? LOAD : IDLE) :
                  state == LOAD  ? PHASE :
                  state == PHASE ? (last ? DONE : PHASE) : IDLE;
   end
   // Active pairs of a phase never overlap, so each swap writes its own two slots.
   always_comb begin
      for (int j = 0; j < K; j++) begin
         nx[j] = vx[j];
         ny[j] = vy[j];
      end
      for (int j = 0; j < K - 1; j++) begin
         cr[j] = XW'(vx[j]) * XW'(vy[j+1]) - XW'(vy[j]) * XW'(vx[j+1]);
         sw[j] = (j[0] == cnt[0]) && (ccw_q ? cr[j] < 0 : cr[j] > 0);
         if (sw[j]) begin
            nx[j] = vx[j+1];
            ny[j] = vy[j+1];
            nx[j+1] = vx[j];
            ny[j+1] = vy[j];
         end
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt <= '0;
         pts_q <= '0;
         bus.done <= 1'b0;
         bus.pts_out <= '0;
         for (int j = 0; j < K; j++) begin
            vx[j] <= '0;
            vy[j] <= '0;
         end
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: if (bus.start) pts_q <= bus.pts_in;
            LOAD: begin
               cnt <= '0;
               for (int j = 0; j < K; j++) begin
                  vx[j] <= $signed({1'b0, pts_q[(j+1)*PW+COORD_W +: COORD_W]}) - $signed({1'b0, pts_q[COORD_W +: COORD_W]});
                  vy[j] <= $signed({1'b0, pts_q[(j+1)*PW +: COORD_W]}) - $signed({1'b0, pts_q[0 +: COORD_W]});
               end
            end
            PHASE: begin
               if (!last) cnt <= cnt + 1'b1;
               vx <= nx;
               vy <= ny;
            end
            DONE: begin
               bus.done <= 1'b1;
               bus.pts_out[PW-1:0] <= pts_q[PW-1:0];
               for (int j = 0; j < K; j++) begin
                  bus.pts_out[(j+1)*PW+COORD_W +: COORD_W] <= vx[j][COORD_W-1:0] + pts_q[COORD_W +: COORD_W];
                  bus.pts_out[(j+1)*PW +: COORD_W] <= vy[j][COORD_W-1:0] + pts_q[0 +: COORD_W];
               end
            end
            default: ;
         endcase
      end
endmodule
